// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and the ID/EX register layout for the operand fetch stage.
// An all-zero ID/EX entry is a bubble.
package operand_fetch_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic [XLEN-1:0]       op1;
        logic [XLEN-1:0]       op2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [CTRL_W-1:0]     ctrl;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// One source operand: picks bypass/register-file data and flags a hazard for that rs.
// OPFETCH_FORWARD_EN selects the bypass network; otherwise any in-flight writer interlocks.
module operand_bypass_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       read_data,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       operand,
    output logic                  hazard
);
    logic rs_nz, ex_match, mem_match, wb_match;

    // rs != 0 also guarantees a matching rd is nonzero, so x0 writers never hit.
    assign rs_nz     = |rs;
    assign ex_match  = rs_nz & ex_valid & ex_reg_write & (ex_rd == rs);
    assign mem_match = rs_nz & mem_reg_write & (mem_rd == rs);
    assign wb_match  = rs_nz & wb_reg_write & (wb_rd == rs);

`ifdef OPFETCH_FORWARD_EN
    always_comb begin
        hazard  = rs_nz & ex_valid & ex_mem_read & (ex_rd == rs);
        operand = read_data;
        if (!rs_nz)
            operand = '0;
        else if (ex_match & ~ex_mem_read)
            operand = ex_alu_result;
        else if (mem_match)
            operand = mem_result;
        else if (wb_match)
            operand = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_alu_result, mem_result, wb_data, ex_mem_read};

    always_comb begin
        hazard  = ex_match | mem_match | wb_match;
        operand = rs_nz ? read_data : '0;
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// ID-stage operand fetch with hazard/hold/flush control and the ID/EX register.
// Bypass vs. interlock behaviour is selected by OPFETCH_FORWARD_EN.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [CTRL_W-1:0]     id_ctrl,
    output logic [REG_ADDR_W-1:0] read_reg_1,
    output logic [REG_ADDR_W-1:0] read_reg_2,
    input  logic [XLEN-1:0]       read_data_1,
    input  logic [XLEN-1:0]       read_data_2,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ex_hold,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_pc,
    output logic [CTRL_W-1:0]     ex_ctrl
);
    idex_t           idex_q, idex_d;
    logic [XLEN-1:0] op1, op2;
    logic            haz1, haz2, hazard;

    assign read_reg_1 = id_rs1;
    assign read_reg_2 = id_rs2;

    operand_bypass_mux u_op1 (
        .rs(id_rs1), .read_data(read_data_1),
        .ex_valid(idex_q.valid), .ex_reg_write(idex_q.reg_write),
        .ex_mem_read(idex_q.mem_read), .ex_rd(idex_q.rd), .ex_alu_result(ex_alu_result),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .operand(op1), .hazard(haz1)
    );

    operand_bypass_mux u_op2 (
        .rs(id_rs2), .read_data(read_data_2),
        .ex_valid(idex_q.valid), .ex_reg_write(idex_q.reg_write),
        .ex_mem_read(idex_q.mem_read), .ex_rd(idex_q.rd), .ex_alu_result(ex_alu_result),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .operand(op2), .hazard(haz2)
    );

    // Flush outranks hold and hazards: the ID instruction is dropped, nothing stalls.
    always_comb begin
        hazard   = id_valid & (haz1 | haz2);
        stall_id = ~flush & (ex_hold | hazard);
        idex_d   = IDEX_BUBBLE;
        if (flush) begin
            idex_d = IDEX_BUBBLE;
        end else if (ex_hold) begin
            idex_d = idex_q;
        end else if (id_valid & ~hazard) begin
            idex_d.valid     = 1'b1;
            idex_d.rd        = id_rd;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
            idex_d.op1       = op1;
            idex_d.op2       = op2;
            idex_d.imm       = id_imm;
            idex_d.pc        = id_pc;
            idex_d.ctrl      = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            idex_q <= IDEX_BUBBLE;
        else
            idex_q <= idex_d;
    end

    assign ex_valid     = idex_q.valid;
    assign ex_op1       = idex_q.op1;
    assign ex_op2       = idex_q.op2;
    assign ex_rd        = idex_q.rd;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_mem_read  = idex_q.mem_read;
    assign ex_imm       = idex_q.imm;
    assign ex_pc        = idex_q.pc;
    assign ex_ctrl      = idex_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Random + directed check of operand_fetch_stage against a behavioural model of the ID/EX stage.
// Follows OPFETCH_FORWARD_EN the same way the design does.
module tb_operand_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_reg_write, id_mem_read;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, read_reg_1, read_reg_2, ex_rd;
    logic [31:0] id_imm, id_pc, read_data_1, read_data_2, ex_alu_result, mem_result, wb_data;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic [15:0] id_ctrl, ex_ctrl;
    logic        mem_reg_write, wb_reg_write, ex_hold, flush;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic        rw, mr;
        logic [31:0] op1, op2, imm, pc;
        logic [15:0] ctrl;
    } exp_t;
    exp_t m;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2), .ex_alu_result(ex_alu_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value the instruction in ID should see for one source register.
    function automatic logic [31:0] exp_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
`ifdef OPFETCH_FORWARD_EN
        if (m.v && m.rw && !m.mr && m.rd == rs) return ex_alu_result;
        if (mem_reg_write && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd == rs) return wb_data;
`endif
        return rf;
    endfunction

    // Whether this source register forces the ID instruction to wait.
    function automatic bit blocked(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
`ifdef OPFETCH_FORWARD_EN
        return m.v && m.mr && m.rd == rs;
`else
        return (m.v && m.rw && m.rd == rs) || (mem_reg_write && mem_rd == rs) ||
               (wb_reg_write && wb_rd == rs);
`endif
    endfunction

    task automatic idle();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; id_imm = 0; id_pc = 0; id_ctrl = 0;
        read_data_1 = 0; read_data_2 = 0; ex_alu_result = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0; ex_hold = 0; flush = 0;
    endtask

    task automatic rand_in();
        id_valid = ($urandom_range(0, 9) < 8);
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 3) == 0);
        id_imm = $urandom; id_pc = $urandom; id_ctrl = 16'($urandom);
        read_data_1 = $urandom; read_data_2 = $urandom; ex_alu_result = $urandom;
        mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom_range(0, 1));
        mem_result = $urandom;
        wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom_range(0, 1));
        wb_data = $urandom;
        ex_hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 11) == 0);
        rst = ($urandom_range(0, 99) == 0);
    endtask

    // Check combinational outputs, advance one clock, check the ID/EX register.
    task automatic cycle();
        exp_t n;
        bit hz;
        #1;
        hz = id_valid && (blocked(id_rs1) || blocked(id_rs2));
        chk("stall_id", {31'd0, stall_id}, {31'd0, !flush && (ex_hold || hz)});
        chk("read_reg_1", {27'd0, read_reg_1}, {27'd0, id_rs1});
        chk("read_reg_2", {27'd0, read_reg_2}, {27'd0, id_rs2});
        n = m;
        if (rst || flush || (!ex_hold && (!id_valid || hz)))
            n = '0;
        else if (!ex_hold)
            n = '{1'b1, id_rd, id_reg_write, id_mem_read, exp_operand(id_rs1, read_data_1),
                  exp_operand(id_rs2, read_data_2), id_imm, id_pc, id_ctrl};
        @(posedge clk); #1;
        m = n;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
        if (m.v) begin
            chk("ex_op1", ex_op1, m.op1);
            chk("ex_op2", ex_op2, m.op2);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
            chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, m.ctrl});
        end
    endtask

    initial begin
        idle();
        rand_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op1", ex_op1, 32'd0);
        chk("rst_op2", ex_op2, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ctl", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_ctrl", {16'd0, ex_ctrl}, 32'd0);
        m = '0;

`ifdef OPFETCH_FORWARD_EN
        // MEM bypass
        idle(); id_valid = 1; id_rs1 = 3; read_data_1 = 32'h5555;
        mem_rd = 3; mem_reg_write = 1; mem_result = 32'h1234;
        #1 chk("mem_fwd_stall", {31'd0, stall_id}, 32'd0);
        cycle();
        chk("mem_fwd_op1", ex_op1, 32'h1234);

        // load-use: one stall, then MEM bypass of the loaded value
        idle(); id_valid = 1; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
        cycle();
        idle(); id_valid = 1; id_rs2 = 5; id_rd = 6; id_reg_write = 1;
        #1 chk("lu_stall", {31'd0, stall_id}, 32'd1);
        cycle();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'hCAFE;
        #1 chk("lu_release", {31'd0, stall_id}, 32'd0);
        cycle();
        chk("lu_op2", ex_op2, 32'hCAFE);

        // EX > MEM > WB priority, and x0 always reads zero
        idle(); id_valid = 1; id_rd = 7; id_reg_write = 1;
        cycle();
        ex_alu_result = 32'h1; mem_rd = 7; mem_reg_write = 1; mem_result = 32'h2;
        wb_rd = 7; wb_reg_write = 1; wb_data = 32'h3; id_rs1 = 7;
        cycle();
        chk("prio_op1", ex_op1, 32'h1);
        id_rs1 = 0; read_data_1 = 32'hFFFF;
        cycle();
        chk("x0_op1", ex_op1, 32'h0);

        // flush beats hold and load-use
        idle(); id_valid = 1; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
        cycle();
        idle(); id_valid = 1; id_rs1 = 5; ex_hold = 1; flush = 1;
        #1 chk("flush_stall", {31'd0, stall_id}, 32'd0);
        cycle();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
`else
        // interlock: ALU writer of x4 keeps ID stalled while in EX, MEM and WB
        idle(); id_valid = 1; id_rd = 4; id_reg_write = 1;
        cycle();
        idle(); id_valid = 1; id_rs1 = 4; id_rd = 1; read_data_1 = 32'hABCD;
        mem_rd = 4; wb_rd = 4;
        for (int i = 0; i < 4; i++) begin
            mem_reg_write = (i == 1);
            wb_reg_write  = (i == 2);
            #1 chk("ilk_stall", {31'd0, stall_id}, (i < 3) ? 32'd1 : 32'd0);
            cycle();
        end
        chk("ilk_valid", {31'd0, ex_valid}, 32'd1);
        chk("ilk_op1", ex_op1, 32'hABCD);
`endif

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
